// File: rtl/labs_sequence_source.sv
// labs_sequence_source
//   Producer of the sequence/energy stream consumed by the minimum-energy
//   tracker. A start pulse enumerates every symmetry-reduced binary sequence
//   of length SEQ_WIDTH. The LABS energy of each sequence is built up one
//   autocorrelation lag per cycle, so a new beat appears every SEQ_WIDTH-1
//   cycles.
//
// Parameters
//   SEQ_WIDTH  sequence length N in bits (>= 3)
//   E_WIDTH    energy width; accumulation saturates at all-ones
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   i_start    start pulse, sampled only in IDLE
//   i_first    first counter value of the run (LABS_SRC_PARTITION_EN only)
//   i_last     last counter value of the run  (LABS_SRC_PARTITION_EN only)
//   o_busy     high while enumerating; this is also the FSM state (1 = CALC)
//   o_done     one-cycle pulse, coincident with the final o_valid
//   o_seq      sequence bits, bit i = 1 means s_i = -1
//   o_e        energy of o_seq
//   o_valid    one-cycle beat qualifier
//
// Stream handshake: there is no ready. The consumer must capture
// {o_seq, o_e} in every cycle where o_valid is high. o_seq and o_e hold
// their values between beats.
//
// Optional feature, macro LABS_SRC_PARTITION_EN: adds i_first/i_last so
// that several instances can split the search space. When i_first > i_last
// only the sequence for i_first is emitted.

module labs_sequence_source #(
    parameter int SEQ_WIDTH = 8,
    parameter int E_WIDTH   = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
`ifdef LABS_SRC_PARTITION_EN
    input  logic [SEQ_WIDTH-3:0] i_first,
    input  logic [SEQ_WIDTH-3:0] i_last,
`endif
    output logic                 o_busy,
    output logic                 o_done,
    output logic [SEQ_WIDTH-1:0] o_seq,
    output logic [E_WIDTH-1:0]   o_e,
    output logic                 o_valid
);

    localparam int CNT_W = SEQ_WIDTH - 2;
    localparam int CW    = $clog2(SEQ_WIDTH) + 1;
    localparam int SQW   = 2 * CW;
    localparam int SUMW  = ((E_WIDTH > SQW) ? E_WIDTH : SQW) + 1;

    localparam logic [CNT_W-1:0]   LIMIT  = '1;
    localparam logic [CW-1:0]      K_LAST = CW'(SEQ_WIDTH - 1);
    localparam logic [CW-1:0]      N_C    = CW'(SEQ_WIDTH);
    localparam logic [E_WIDTH-1:0] E_MAX  = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_counter;
    logic [CNT_W-1:0]     r_last;
    logic [CW-1:0]        r_k;
    logic [E_WIDTH-1:0]   r_acc;

    logic [SEQ_WIDTH-1:0] w_cur_seq;
    logic [SEQ_WIDTH-1:0] w_mask;
    logic [SEQ_WIDTH-1:0] w_diff;
    logic [CW-1:0]        w_pop;
    logic [CW-1:0]        w_ck;
    logic [CW-1:0]        w_abs;
    logic [SQW-1:0]       w_sq;
    logic [SUMW-1:0]      w_sum;
    logic [E_WIDTH-1:0]   w_acc_next;
    logic [CNT_W-1:0]     w_first;
    logic [CNT_W-1:0]     w_range_last;
    logic                 w_start_ok;
    logic                 w_last_k;
    logic                 w_last_seq;

    // Bits 0 and 1 are pinned to +1: negation and alternating-sign symmetry
    // leave every energy class represented with that prefix.
    assign w_cur_seq = {r_counter, 2'b00};

    // Lag-k correlation: products s_i*s_{i+k} are -1 exactly where the bits
    // differ, so C_k = (N-k) - 2*(number of differing pairs).
    assign w_mask = {SEQ_WIDTH{1'b1}} >> r_k;
    assign w_diff = (w_cur_seq ^ (w_cur_seq >> r_k)) & w_mask;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < SEQ_WIDTH; i++) begin
            w_pop = w_pop + CW'(w_diff[i]);
        end
    end

    assign w_ck  = N_C - r_k - (w_pop << 1);
    assign w_abs = w_ck[CW-1] ? (~w_ck + CW'(1)) : w_ck;
    assign w_sq  = SQW'(w_abs) * SQW'(w_abs);

    // Sum is formed one bit wider than both operands so the clamp sees any
    // overflow instead of a wrapped value.
    assign w_sum      = SUMW'(r_acc) + SUMW'(w_sq);
    assign w_acc_next = (w_sum > SUMW'(E_MAX)) ? E_MAX : w_sum[E_WIDTH-1:0];

`ifdef LABS_SRC_PARTITION_EN
    // A reversed range collapses to the single sequence at i_first.
    assign w_first      = i_first;
    assign w_range_last = (i_first > i_last) ? i_first : i_last;
`else
    assign w_first      = '0;
    assign w_range_last = LIMIT;
`endif

    // A start arriving while the done pulse is still showing belongs to the
    // run that just ended and is dropped; a restart needs a fresh pulse.
    assign w_start_ok = i_start && !o_done;
    assign w_last_k   = (r_k == K_LAST);
    assign w_last_seq = (r_counter == r_last);

    assign o_busy = (r_state == ST_CALC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last_k && w_last_seq) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter <= '0;
            r_last    <= LIMIT;
            r_k       <= CW'(1);
            r_acc     <= '0;
            o_seq     <= '0;
            o_e       <= E_MAX;
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_counter <= w_first;
                        r_last    <= w_range_last;
                        r_k       <= CW'(1);
                        r_acc     <= '0;
                    end
                end
                ST_CALC: begin
                    if (!w_last_k) begin
                        r_acc <= w_acc_next;
                        r_k   <= r_k + CW'(1);
                    end else begin
                        o_seq   <= w_cur_seq;
                        o_e     <= w_acc_next;
                        o_valid <= 1'b1;
                        r_acc   <= '0;
                        r_k     <= CW'(1);
                        if (w_last_seq) begin
                            o_done <= 1'b1;
                        end else begin
                            r_counter <= r_counter + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_labs_sequence_source.sv
// tb_labs_sequence_source
//   Three instances: A (N=4, E=20), B (N=8, E=20), C (N=8, E=4, saturating).
//   Expected beats come from a +1/-1 correlation model and a cycle timeline
//   derived from the stream timing rules. Cycle c means: inputs are sampled
//   at clock edge c, and outputs observed in cycle c were registered at
//   edge c-1.

module tb_labs_sequence_source;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    int         sel;
    logic [5:0] first_in;
    logic [5:0] last_in;

    logic sa, sb, sc;
    assign sa = start && (sel == 0);
    assign sb = start && (sel == 1);
    assign sc = start && (sel == 2);

    logic        a_busy, a_done, a_valid;
    logic [3:0]  a_seq;
    logic [19:0] a_e;
    logic        b_busy, b_done, b_valid;
    logic [7:0]  b_seq;
    logic [19:0] b_e;
    logic        c_busy, c_done, c_valid;
    logic [7:0]  c_seq;
    logic [3:0]  c_e;

    labs_sequence_source #(.SEQ_WIDTH(4), .E_WIDTH(20)) u_a (
        .clk(clk), .rst(rst), .i_start(sa),
`ifdef LABS_SRC_PARTITION_EN
        .i_first(first_in[1:0]), .i_last(last_in[1:0]),
`endif
        .o_busy(a_busy), .o_done(a_done), .o_seq(a_seq), .o_e(a_e), .o_valid(a_valid)
    );

    labs_sequence_source #(.SEQ_WIDTH(8), .E_WIDTH(20)) u_b (
        .clk(clk), .rst(rst), .i_start(sb),
`ifdef LABS_SRC_PARTITION_EN
        .i_first(first_in), .i_last(last_in),
`endif
        .o_busy(b_busy), .o_done(b_done), .o_seq(b_seq), .o_e(b_e), .o_valid(b_valid)
    );

    labs_sequence_source #(.SEQ_WIDTH(8), .E_WIDTH(4)) u_c (
        .clk(clk), .rst(rst), .i_start(sc),
`ifdef LABS_SRC_PARTITION_EN
        .i_first(first_in), .i_last(last_in),
`endif
        .o_busy(c_busy), .o_done(c_done), .o_seq(c_seq), .o_e(c_e), .o_valid(c_valid)
    );

    logic [31:0] obs_seq, obs_e, obs_valid, obs_done, obs_busy;
    always_comb begin
        case (sel)
            0: begin
                obs_seq = 32'(a_seq); obs_e = 32'(a_e);
                obs_valid = 32'(a_valid); obs_done = 32'(a_done); obs_busy = 32'(a_busy);
            end
            1: begin
                obs_seq = 32'(b_seq); obs_e = 32'(b_e);
                obs_valid = 32'(b_valid); obs_done = 32'(b_done); obs_busy = 32'(b_busy);
            end
            default: begin
                obs_seq = 32'(c_seq); obs_e = 32'(c_e);
                obs_valid = 32'(c_valid); obs_done = 32'(c_done); obs_busy = 32'(c_busy);
            end
        endcase
    end

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int held_seq[3];
    int held_e[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int s);
        return (s == 0) ? 4 : 8;
    endfunction

    function automatic int emax_of(input int s);
        return (s == 2) ? 15 : ((1 << 20) - 1);
    endfunction

    function automatic void reset_held();
        for (int i = 0; i < 3; i++) begin
            held_seq[i] = 0;
            held_e[i]   = emax_of(i);
        end
    endfunction

    // Reference energy: sum over lags of (sum_i s_i*s_{i+k})^2, clamped.
    function automatic int labs_energy(input int n, input int seq, input int emax);
        int e;
        int c;
        int si;
        int sj;
        e = 0;
        for (int k = 1; k < n; k++) begin
            c = 0;
            for (int i = 0; i < n - k; i++) begin
                si = ((seq >> i) & 1) ? -1 : 1;
                sj = ((seq >> (i + k)) & 1) ? -1 : 1;
                c += si * sj;
            end
            e += c * c;
        end
        return (e > emax) ? emax : e;
    endfunction

    // ---------------- driver + per-cycle checker ----------------
    // rst_at < 0: no reset. xs1/xs2: extra start pulses (cycle numbers, < 0 = none).
    task automatic run_stream(input int s, input int first, input int last,
                              input int rst_at, input int xs1, input int xs2);
        logic [7:0] exp_q[$];
        logic [7:0] sq;
        int n, emax, nb, last_valid, beats, obs_min, exp_min, ev, ed, eb, en;
        bit aborted;
        n    = n_of(s);
        emax = emax_of(s);
        exp_q.delete();
        if (first > last) exp_q.push_back(8'(first << 2));
        else for (int v = first; v <= last; v++) exp_q.push_back(8'(v << 2));
        nb         = exp_q.size();
        last_valid = n + (nb - 1) * (n - 1);
        exp_min    = 32'h7fffffff;
        foreach (exp_q[i]) begin
            en = labs_energy(n, int'(exp_q[i]), emax);
            if (en < exp_min) exp_min = en;
        end
        beats   = 0;
        obs_min = 32'h7fffffff;
        aborted = 1'b0;

        @(negedge clk);
        sel      = s;
        first_in = 6'(first);
        last_in  = 6'(last);
        start    = 1'b1;
        rst      = 1'b0;
        for (int c = 1; c <= last_valid + 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rst_at >= 0 && c > rst_at && !aborted) begin
                aborted = 1'b1;
                reset_held();
            end
            ev = 0; ed = 0; eb = 0;
            if (!aborted) begin
                eb = (c < last_valid) ? 1 : 0;
                if (c >= n && ((c - n) % (n - 1)) == 0 && exp_q.size() > 0) begin
                    sq          = exp_q.pop_front();
                    ev          = 1;
                    ed          = (exp_q.size() == 0) ? 1 : 0;
                    held_seq[s] = int'(sq);
                    held_e[s]   = labs_energy(n, int'(sq), emax);
                end
            end
            check_eq($sformatf("valid s%0d c%0d", s, c), obs_valid, ev);
            check_eq($sformatf("done s%0d c%0d", s, c), obs_done, ed);
            check_eq($sformatf("busy s%0d c%0d", s, c), obs_busy, eb);
            check_eq($sformatf("seq s%0d c%0d", s, c), obs_seq, held_seq[s]);
            check_eq($sformatf("e s%0d c%0d", s, c), obs_e, held_e[s]);
            if (obs_valid[0]) begin
                beats++;
                check_eq($sformatf("seq_lsb s%0d c%0d", s, c), obs_seq & 32'd3, 0);
                if (int'(obs_e) < obs_min) obs_min = int'(obs_e);
            end
            start = (c == xs1) || (c == xs2);
            rst   = (rst_at >= 0 && c == rst_at);
        end
        start = 1'b0;
        rst   = 1'b0;
        if (rst_at < 0) begin
            check_eq($sformatf("beats s%0d", s), beats, nb);
            check_eq($sformatf("min_e s%0d", s), obs_min, exp_min);
        end
    endtask

    // ---------------- main sequence ----------------
    int r_at, x1, x2, f, l;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        sel      = 0;
        first_in = '0;
        last_in  = '0;
        reset_held();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_eq($sformatf("rst_seq s%0d", s), obs_seq, 0);
            check_eq($sformatf("rst_e s%0d", s), obs_e, emax_of(s));
            check_eq($sformatf("rst_valid s%0d", s), obs_valid, 0);
            check_eq($sformatf("rst_done s%0d", s), obs_done, 0);
            check_eq($sformatf("rst_busy s%0d", s), obs_busy, 0);
        end

        // N=4 baseline, reset mid-run, rerun, ignored restarts.
        run_stream(0, 0, 3, -1, -1, -1);
        run_stream(0, 0, 3, 6, -1, -1);
        run_stream(0, 0, 3, -1, -1, -1);
        run_stream(0, 0, 3, -1, 3, 13);

        // Start and reset on the same edge: reset wins, nothing starts.
        @(negedge clk);
        sel   = 0;
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        reset_held();
        check_eq("rst_wins_busy", obs_busy, 0);
        repeat (5) @(negedge clk);
        check_eq("rst_wins_valid", obs_valid, 0);
        check_eq("rst_wins_busy2", obs_busy, 0);

        // Randomized N=4 runs: random reset point and ignored start pulses.
        repeat (8) begin
            r_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1;
            x1   = int'($urandom_range(1, (r_at >= 0) ? r_at : 13));
            x2   = int'($urandom_range(1, (r_at >= 0) ? r_at : 13));
            run_stream(0, 0, 3, r_at, x1, x2);
        end

        // Full N=8 runs, then saturating energy width.
        run_stream(1, 0, 63, -1, int'($urandom_range(1, 449)), -1);
        run_stream(2, 0, 63, -1, -1, -1);
        run_stream(1, 0, 63, int'($urandom_range(1, 440)), -1, -1);

`ifdef LABS_SRC_PARTITION_EN
        run_stream(1, 5, 7, -1, -1, -1);
        run_stream(1, 9, 2, -1, -1, -1);
        repeat (4) begin
            f = int'($urandom_range(0, 63));
            l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                            : ((f + int'($urandom_range(0, 5)) > 63) ? 63 : f + int'($urandom_range(0, 5)));
            run_stream(1, f, l, -1, -1, -1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
